uart_rx: RTL
============

Name: uart_rx

Overview:
- UART receive stage directly downstream of the baud generator.
- Consumes its oversampling tick (BAUD_RATE × OVERSAMPLING_RATE) and deserialises 8N1 frames from the asynchronous rx line.
- Delivers each byte through a one-entry valid/ready holding register to the system-side consumer.
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
- OVERSAMPLING_RATE, 16, ticks per bit; even, ≥4; must match the baud generator setting.
- DATA_BITS, 8, data bits per frame, 5..9.
- SYNC_STAGES, 2, flip-flops in the rx_in synchroniser, ≥2.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset; synchronous, active-high.
- baudclk_in  input  1  oversampling clock from the baud generator, synchronous to clk_in; each rising edge (detected internally, 0→1 between consecutive clk_in samples) is one tick.
- rx_in  input  1  asynchronous serial line, idle high.
- data_out  output  DATA_BITS  received byte, valid while valid_out=1.
- valid_out  output  1  holding register full.
- ready_in  input  1  consumer accepts data_out when valid_out & ready_in at a clk_in edge.
- frame_err_out  output  1  one-cycle pulse: stop bit sampled low.
- overrun_out  output  1  one-cycle pulse: byte completed while holding register full and not being read.

Behaviour:
- Reset (rst_in=1 at clk_in edge): state IDLE, counters 0, shift register 0, data_out=0, valid_out=0, frame_err_out=0, overrun_out=0, idle_armed=0. Synchroniser stages reset to 1. Reset mid-frame abandons the frame silently.
- rx_s: rx_in after SYNC_STAGES flops. tick: one-cycle strobe, 1 clk_in after a rising edge of baudclk_in. All FSM activity occurs only on tick cycles, except the output handshake.
- tick_cnt: log2(OVERSAMPLING_RATE) bits. bit_cnt: counts 0..DATA_BITS-1.
- IDLE:
  - On tick with rx_s=1: idle_armed←1.
  - On tick with rx_s=0 and idle_armed=1: →START, tick_cnt←0.
- START:
  - On tick: tick_cnt++.
  - When tick_cnt reaches OVERSAMPLING_RATE/2-1 (mid start bit): if rx_s=0 → DATA, tick_cnt←0, bit_cnt←0. Otherwise glitch → IDLE, no error reported.
- DATA:
  - On tick: tick_cnt++.
  - At tick_cnt=OVERSAMPLING_RATE-1 (mid bit): shift rx_s into shift register MSB, shifting right (LSB first on the line), tick_cnt←0.
  - If bit_cnt=DATA_BITS-1 → STOP (→PARITY when the optional feature is enabled); else bit_cnt++.
- STOP:
  - At tick_cnt=OVERSAMPLING_RATE-1: sample rx_s, → IDLE (early resync, half a bit before the stop-bit end).
  - rx_s=1: byte complete.
  - rx_s=0: frame_err_out pulses, byte discarded, idle_armed←0 (a held-low break yields exactly one error).
- Byte complete:
  - valid_out=0, or valid_out & ready_in in the same cycle: data_out←shift register, valid_out←1 on the next clk_in edge, no overrun.
  - Otherwise: overrun_out pulses, new byte dropped, data_out/valid_out unchanged.
- Handshake: valid_out & ready_in with no completion that cycle → valid_out←0 next edge. data_out holds its last value after the read.
- Latency: valid_out rises 1 clk_in after the tick that samples the stop bit.
- Pulses are never asserted while rst_in=1.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP; samples one bit at mid-bit timing.
  - Adds input parity_odd_in (0=even, 1=odd) and output parity_err_out (one-cycle pulse at stop-bit sampling when parity mismatches).
  - A byte with a parity error is still delivered. Frame error takes precedence: on a frame error no parity_err_out pulse.
- Undefined: no PARITY state, no extra ports, 8N1 only.

Decomposition:
- Package uart_pkg: state enum typedef (IDLE, START, DATA, PARITY, STOP); default OVERSAMPLING_RATE and DATA_BITS localparams shared with the baud generator and future uart_tx.
- Sub-module uart_rx_sync: SYNC_STAGES synchroniser for rx_in plus the baudclk_in rising-edge detector producing tick.

Test Plan:
- 100 MHz clk_in, baud generator at 230400 baud ×16, send 0xA5 8N1 with ready_in=1 → valid_out high one cycle, data_out=0xA5, no error pulses.
- Send 0x3C then 0xC3 back-to-back with ready_in=0 → first stays 0x3C, overrun_out one pulse at second stop-bit sampling; then ready_in=1 → valid_out falls next edge.
- Low glitch of 4 ticks on idle line → returns to IDLE, valid_out and frame_err_out stay 0.
- Frame 0x55 with stop bit forced low, then line held low for 3 frame times → exactly one frame_err_out pulse, no valid_out; release line, send 0x0F → received 0x0F.
- Assert rst_in for 1 cycle in the middle of bit 4 of a frame → all outputs 0, partial frame discarded, next frame 0x81 received correctly.
- With UART_RX_PARITY_EN, parity_odd_in=0, send 0x07 with parity bit 0 → data_out=0x07, parity_err_out one pulse; with parity bit 1 → no pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default frame and
// oversampling settings used by the baud generator, uart_rx and uart_tx.
package uart_pkg;

    localparam int UART_OVERSAMPLING_RATE = 16;
    localparam int UART_DATA_BITS         = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous rx line into the clk_in domain and turns rising
// edges of the baud generator's oversampling clock into one-cycle ticks.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rx_in,
    input  logic baudclk_in,
    output logic rx_s,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   baud_q;

    // Synchroniser resets to the idle-high line level so reset never looks like a start bit
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync_q <= '1;
            baud_q <= 1'b0;
            tick   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
            baud_q <= baudclk_in;
            tick   <= baudclk_in & ~baud_q;
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: deserialises frames on oversampling ticks into a one-entry
// valid/ready holding register. Define UART_RX_PARITY_EN for a parity bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLING_RATE = UART_OVERSAMPLING_RATE,
    parameter int DATA_BITS         = UART_DATA_BITS,
    parameter int SYNC_STAGES       = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 baudclk_in,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 frame_err_out,
    output logic                 overrun_out
`ifdef UART_RX_PARITY_EN
    ,
    input  logic                 parity_odd_in,
    output logic                 parity_err_out
`endif
);

    localparam int TW = $clog2(OVERSAMPLING_RATE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLING_RATE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLING_RATE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic rx_s;
    logic tick;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rx_in      (rx_in),
        .baudclk_in (baudclk_in),
        .rx_s       (rx_s),
        .tick       (tick)
    );

    uart_state_t          state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 idle_armed_q, idle_armed_d;
    logic [DATA_BITS-1:0] data_d;
    logic                 valid_d;
    logic                 frame_err_d;
    logic                 overrun_d;
    logic                 byte_done;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bit_q, parity_bit_d;
    logic                 parity_err_d;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= IDLE;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            idle_armed_q  <= 1'b0;
            data_out      <= '0;
            valid_out     <= 1'b0;
            frame_err_out <= 1'b0;
            overrun_out   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q   <= 1'b0;
            parity_err_out <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            idle_armed_q  <= idle_armed_d;
            data_out      <= data_d;
            valid_out     <= valid_d;
            frame_err_out <= frame_err_d;
            overrun_out   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_bit_q   <= parity_bit_d;
            parity_err_out <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        idle_armed_d = idle_armed_q;
        data_d       = data_out;
        valid_d      = valid_out;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        byte_done    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_d = parity_bit_q;
        parity_err_d = 1'b0;
`endif

        if (valid_out && ready_in) begin
            valid_d = 1'b0;
        end

        if (tick) begin
            case (state_q)
                // A start is only accepted after the line has been seen high,
                // so a held-low break cannot retrigger frames
                IDLE: begin
                    if (rx_s) begin
                        idle_armed_d = 1'b1;
                    end else if (idle_armed_q) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                    end
                end
                START: begin
                    if (tick_cnt_q == TICK_MID) begin
                        if (!rx_s) begin
                            state_d    = DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                DATA: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d   = '0;
                        parity_bit_d = rx_s;
                        state_d      = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
`endif
                // Stop bit is judged at mid-bit and the FSM returns to IDLE
                // immediately, leaving half a bit of margin for the next start
                STOP: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = IDLE;
                        if (rx_s) begin
                            byte_done = 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err_d = ((^shift_q) ^ parity_bit_q) != parity_odd_in;
`endif
                        end else begin
                            frame_err_d  = 1'b1;
                            idle_armed_d = 1'b0;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // A read in the same cycle frees the holding register for the new byte
        if (byte_done) begin
            if (!valid_out || ready_in) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

endmodule
